// File: rtl/vt_ctrl_pkg.sv
// Shared constants, state encoding and sizing helpers
// for the VisionTransformer patch scheduler.
package vt_ctrl_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BASE   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_CNT_LSB = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  function automatic int n_patch(input int dim, input int p);
    return dim / p;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/vt_wb_regs.sv
// Wishbone slave: decode, single-cycle ack, CTRL/STATUS/IMG_BASE
// storage, START/ABORT pulses and the sticky W1C DONE flag.
module vt_wb_regs
  import vt_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        busy,
  input  logic        done_set,
  input  logic [15:0] done_cnt,
  output logic        start,
  output logic        abort,
  output logic        irq_en,
  output logic [31:0] img_base,
  output logic        irq
);

  logic        hit;
  logic        req;
  logic        wr;
  logic        w1c;
  logic        done_q;
  logic [1:0]  idx;
  logic [31:0] rdata;
  logic        unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  assign hit = wbs_adr_i[31:4] == BASE_ADDR[31:4];
  // ~ack keeps back-to-back strobes from acking twice in a row
  assign req = wbs_stb_i & wbs_cyc_i & hit & ~wbs_ack_o;
  assign wr  = req & wbs_we_i;
  assign idx = wbs_adr_i[3:2];

  assign start = wr & (idx == REG_CTRL) & wbs_sel_i[0]
               & wbs_dat_i[CTRL_START];
  assign abort = wr & (idx == REG_CTRL) & wbs_sel_i[0]
               & wbs_dat_i[CTRL_ABORT];
  assign w1c   = wr & (idx == REG_STATUS) & wbs_sel_i[0]
               & wbs_dat_i[STAT_DONE];

  assign irq = done_q & irq_en;

  always_comb begin
    rdata = '0;
    unique case (idx)
      REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
      REG_STATUS: rdata = {done_cnt, 14'b0, done_q, busy};
      REG_BASE:   rdata = img_base;
      REG_RSVD:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_en    <= 1'b0;
      img_base  <= '0;
      done_q    <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      if (req)
        wbs_dat_o <= rdata;
      if (wr && idx == REG_CTRL && wbs_sel_i[0])
        irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      if (wr && idx == REG_BASE)
        for (int b = 0; b < 4; b++)
          if (wbs_sel_i[b])
            img_base[8*b +: 8] <= wbs_dat_i[8*b +: 8];
      if (done_set)
        done_q <= 1'b1;
      else if (w1c || (start && !busy))
        done_q <= 1'b0;
    end
  end

endmodule

// File: rtl/vt_patch_scheduler.sv
// Raster patch walker with credit-limited issue, completion
// counting and frame-done interrupt, configured over Wishbone.
module vt_patch_scheduler
  import vt_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          IMG_WIDTH  = 512,
  parameter int          IMG_HEIGHT = 512,
  parameter int          PATCH      = 16,
  parameter int          MAX_OUTST  = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        patch_valid_o,
  input  logic        patch_ready_i,
  output logic [idx_w(IMG_WIDTH/PATCH)-1:0]  patch_x_o,
  output logic [idx_w(IMG_HEIGHT/PATCH)-1:0] patch_y_o,
  output logic [31:0] patch_addr_o,
  output logic        patch_last_o,
  input  logic        patch_done_i,
  output logic        irq_o
);

  localparam int NPX   = n_patch(IMG_WIDTH, PATCH);
  localparam int NPY   = n_patch(IMG_HEIGHT, PATCH);
  localparam int TOTAL = NPX * NPY;
  localparam int XW    = idx_w(NPX);
  localparam int YW    = idx_w(NPY);
  localparam int CW    = cnt_w(TOTAL);
  localparam int BPP   = DATA_WIDTH / 8;

  localparam logic [31:0] X_STEP = 32'(PATCH * BPP);
  localparam logic [31:0] Y_STEP = 32'(PATCH * IMG_WIDTH * BPP);
  localparam logic [XW-1:0] X_LAST = XW'(NPX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(NPY - 1);

  state_t state;
  state_t nstate;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] issued;
  logic [CW-1:0] completed;
  logic [CW-1:0] outst;
  logic [31:0]   base_q;
  logic [31:0]   img_base;

  logic start;
  logic abort;
  logic irq_en;
  logic busy;
  logic done_set;
  logic hs;
  logic done_ok;
  logic launch;

  vt_wb_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .busy      (busy),
    .done_set  (done_set),
    .done_cnt  (16'(completed)),
    .start     (start),
    .abort     (abort),
    .irq_en    (irq_en),
    .img_base  (img_base),
    .irq       (irq_o)
  );

  assign outst   = issued - completed;
  assign hs      = patch_valid_o & patch_ready_i;
  assign launch  = (state == IDLE) & start;
  assign done_ok = patch_done_i & (outst != '0) & busy;

  assign patch_x_o    = x;
  assign patch_y_o    = y;
  assign patch_addr_o = base_q + 32'(y) * Y_STEP + 32'(x) * X_STEP;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      state <= IDLE;
    else
      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (start) nstate = ISSUE;
      ISSUE: begin
        if (abort)
          nstate = IDLE;
        else if (hs && patch_last_o)
          nstate = DRAIN;
      end
      DRAIN: begin
        if (abort)
          nstate = IDLE;
        else if (completed == CW'(TOTAL))
          nstate = DONE;
      end
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy          = state != IDLE;
    patch_valid_o = (state == ISSUE) && (outst < CW'(MAX_OUTST));
    patch_last_o  = (state == ISSUE) && (x == X_LAST) && (y == Y_LAST);
    done_set      = (state == DONE) && !abort;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      x         <= '0;
      y         <= '0;
      issued    <= '0;
      completed <= '0;
      base_q    <= '0;
    end else if (launch) begin
      x         <= '0;
      y         <= '0;
      issued    <= '0;
      completed <= '0;
      base_q    <= img_base;
    end else begin
      if (hs) begin
        issued <= issued + 1'b1;
        if (x == X_LAST) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (done_ok)
        completed <= completed + 1'b1;
    end
  end

endmodule

// File: tb/tb_vt_patch_scheduler.sv
// Directed + randomized bench for vt_patch_scheduler with a
// raster/credit reference model kept in plain arithmetic.
module tb_vt_patch_scheduler;

  localparam int DW    = 32;
  localparam int IMG_W = 512;
  localparam int IMG_H = 512;
  localparam int PATCH = 16;
  localparam int MAXO  = 4;
  localparam int NPX   = IMG_W / PATCH;
  localparam int NPY   = IMG_H / PATCH;
  localparam int TOTAL = NPX * NPY;
  localparam logic [31:0] BA = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        patch_valid_o, patch_ready_i;
  logic [4:0]  patch_x_o, patch_y_o;
  logic [31:0] patch_addr_o;
  logic        patch_last_o, patch_done_i, irq_o;

  always #5 clk = ~clk;

  vt_patch_scheduler dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_sel_i     (wbs_sel_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .patch_valid_o (patch_valid_o),
    .patch_ready_i (patch_ready_i),
    .patch_x_o     (patch_x_o),
    .patch_y_o     (patch_y_o),
    .patch_addr_o  (patch_addr_o),
    .patch_last_o  (patch_last_o),
    .patch_done_i  (patch_done_i),
    .irq_o         (irq_o)
  );

  int errors = 0;
  int checks = 0;

  int unsigned m_issued, m_completed, cyc_n;
  int unsigned done_q[$];
  logic [31:0] m_img, m_base, a_k1, a_k32;
  bit chk_valid, hold_done, force_done, bp_hold;
  int unsigned rdy_pct, dly_min, dly_max;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int unsigned k);
    int unsigned px, py;
    px = k % NPX;
    py = k / NPX;
    return m_base + py * PATCH * IMG_W * (DW / 8) + px * PATCH * (DW / 8);
  endfunction

  // One clock: observe at negedge, then drive inputs for the next edge.
  task automatic cyc();
    int unsigned ob;
    bit hs;
    @(negedge clk);
    cyc_n++;
    ob = m_issued - m_completed;
    if (chk_valid)
      chk("valid", 32'(patch_valid_o),
          32'(m_issued < TOTAL && ob < MAXO));
    patch_ready_i = !bp_hold && ($urandom_range(99) < rdy_pct);
    hs = patch_valid_o && patch_ready_i;
    if (hs) begin
      chk("patch_x", 32'(patch_x_o), m_issued % NPX);
      chk("patch_y", 32'(patch_y_o), m_issued / NPX);
      chk("patch_addr", patch_addr_o, exp_addr(m_issued));
      chk("patch_last", 32'(patch_last_o), 32'(m_issued == TOTAL - 1));
      if (m_issued == 1) a_k1 = patch_addr_o;
      if (m_issued == NPX) a_k32 = patch_addr_o;
      m_issued++;
      done_q.push_back(cyc_n + $urandom_range(dly_max, dly_min));
    end
    patch_done_i = 1'b0;
    if (force_done) begin
      force_done = 0;
      patch_done_i = 1'b1;
      if (ob > 0) begin
        m_completed++;
        void'(done_q.pop_front());
      end
    end else if (!hold_done && done_q.size() > 0 && done_q[0] <= cyc_n) begin
      void'(done_q.pop_front());
      patch_done_i = 1'b1;
      m_completed++;
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic we,
                         output logic [31:0] rd);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
    chk("ack_before", 32'(wbs_ack_o), 0);
    cyc();
    chk("ack_1cyc", 32'(wbs_ack_o), 1);
    rd = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    cyc();
    chk("ack_once", 32'(wbs_ack_o), 0);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic [31:0] rd;
    wb_xfer(a, d, s, 1'b1, rd);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    wb_xfer(a, 32'h0, 4'hF, 1'b0, rd);
  endtask

  task automatic start_frame();
    chk_valid = 0;
    m_issued = 0;
    m_completed = 0;
    m_base = m_img;
    done_q.delete();
    wb_write(BA + 32'h0, 32'h5, 4'h1);
    chk_valid = 1;
  endtask

  task automatic run_until_issued(input int unsigned n);
    for (int i = 0; i < 5000 && m_issued < n; i++) cyc();
    chk("issue_budget", m_issued >= n, 1);
  endtask

  task automatic drain();
    rdy_pct = 0;
    for (int i = 0; i < 200 && done_q.size() > 0; i++) cyc();
    chk("drain_budget", done_q.size(), 0);
  endtask

  task automatic abort_frame();
    chk_valid = 0;
    wb_write(BA + 32'h0, 32'h6, 4'h1);
  endtask

  logic [31:0] rd;
  int unsigned n0;

  initial begin
    rst = 1'b1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    patch_ready_i = 0; patch_done_i = 0;
    m_img = 0; m_base = 0; m_issued = 0; m_completed = 0; cyc_n = 0;
    chk_valid = 0; hold_done = 0; force_done = 0; bp_hold = 0;
    rdy_pct = 0; dly_min = 3; dly_max = 3;
    a_k1 = 0; a_k32 = 0;

    repeat (3) cyc();
    chk("rst_ack", 32'(wbs_ack_o), 0);
    chk("rst_valid", 32'(patch_valid_o), 0);
    chk("rst_irq", 32'(irq_o), 0);
    chk("rst_addr", patch_addr_o, 0);
    chk("rst_dat", wbs_dat_o, 0);
    rst = 1'b0;
    cyc();

    // register access, byte lanes, reserved slot, decode miss
    wb_write(BA + 32'h8, 32'h1000_0000, 4'hF);
    wb_write(BA + 32'h0, 32'h4, 4'hF);
    wb_read(BA + 32'h8, rd); chk("rd_base", rd, 32'h1000_0000);
    wb_read(BA + 32'h0, rd); chk("rd_ctrl", rd, 32'h4);
    wb_read(BA + 32'h4, rd); chk("rd_status0", rd, 0);
    wb_write(BA + 32'h8, 32'hAABB_CCDD, 4'b0101);
    wb_read(BA + 32'h8, rd); chk("rd_base_sel", rd, 32'h10BB_00DD);
    wb_write(BA + 32'hC, 32'hFFFF_FFFF, 4'hF);
    wb_read(BA + 32'hC, rd); chk("rd_rsvd", rd, 0);
    wb_write(BA + 32'h8, 32'h1000_0000, 4'hF);
    m_img = 32'h1000_0000;
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_adr_i = BA + 32'h10;
    repeat (3) begin
      cyc();
      chk("miss_noack", 32'(wbs_ack_o), 0);
    end
    wbs_stb_i = 0; wbs_cyc_i = 0;

    // full frame, ready held high, done 3 cycles after each issue
    rdy_pct = 100; dly_min = 3; dly_max = 3;
    start_frame();
    for (int i = 0; i < 5000 && irq_o !== 1'b1; i++) cyc();
    chk("frame_irq", 32'(irq_o), 1);
    chk("frame_hs", m_issued, TOTAL);
    chk("addr_1_0", a_k1, 32'h1000_0040);
    chk("addr_0_1", a_k32, 32'h1000_8000);
    wb_read(BA + 32'h4, rd); chk("status_done", rd, 32'h0400_0002);
    wb_write(BA + 32'h4, 32'h2, 4'h1);
    chk("irq_w1c", 32'(irq_o), 0);
    wb_read(BA + 32'h4, rd); chk("status_w1c", rd, 32'h0400_0000);

    // randomized frame with backpressure and writes while busy
    m_img = $urandom;
    wb_write(BA + 32'h8, m_img, 4'hF);
    rdy_pct = 70; dly_min = 1; dly_max = 8;
    start_frame();
    run_until_issued(300);
    wb_write(BA + 32'h0, 32'h5, 4'h1);
    m_img = $urandom;
    wb_write(BA + 32'h8, m_img, 4'hF);
    wb_read(BA + 32'h4, rd); chk("busy_mid", rd & 32'h3, 1);
    run_until_issued(500);
    bp_hold = 1;
    repeat (10) cyc();
    repeat (10) begin
      cyc();
      chk("bp_valid", 32'(patch_valid_o), 1);
      chk("bp_x", 32'(patch_x_o), m_issued % NPX);
      chk("bp_y", 32'(patch_y_o), m_issued / NPX);
      chk("bp_addr", patch_addr_o, exp_addr(m_issued));
    end
    n0 = m_issued;
    bp_hold = 0; rdy_pct = 100;
    cyc();
    chk("bp_release", m_issued, n0 + 1);
    rdy_pct = 70;
    for (int i = 0; i < 20000 && irq_o !== 1'b1; i++) cyc();
    chk("rand_irq", 32'(irq_o), 1);
    chk("rand_hs", m_issued, TOTAL);
    wb_read(BA + 32'h4, rd); chk("rand_status", rd, 32'h0400_0002);
    wb_write(BA + 32'h4, 32'h2, 4'h1);

    // credit limit
    rdy_pct = 100; dly_min = 2; dly_max = 2; hold_done = 1;
    start_frame();
    repeat (20) cyc();
    chk("credit_hs", m_issued, MAXO);
    chk("credit_valid", 32'(patch_valid_o), 0);
    force_done = 1;
    repeat (10) cyc();
    chk("credit_more", m_issued, MAXO + 1);
    hold_done = 0;
    drain();
    abort_frame();

    // abort after 100 handshakes
    rdy_pct = 100; dly_min = 3; dly_max = 3;
    start_frame();
    run_until_issued(100);
    drain();
    chk("pre_abort_hs", m_issued, 100);
    abort_frame();
    chk("abort_valid", 32'(patch_valid_o), 0);
    chk("abort_irq", 32'(irq_o), 0);
    wb_read(BA + 32'h4, rd); chk("abort_status", rd, 32'h0064_0000);

    // restart from (0,0), then START while busy, stray done pulse
    rdy_pct = 100;
    start_frame();
    run_until_issued(40);
    drain();
    wb_write(BA + 32'h0, 32'h5, 4'h1);
    rdy_pct = 100;
    cyc();
    chk("restart_ignored", m_issued, 41);
    drain();
    force_done = 1;
    cyc();
    repeat (2) cyc();
    wb_read(BA + 32'h4, rd); chk("stray_done", rd, (m_completed << 16) | 1);
    chk("stray_cnt", m_completed, 41);

    // reset mid-frame
    rdy_pct = 100;
    run_until_issued(45);
    chk_valid = 0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_valid", 32'(patch_valid_o), 0);
    chk("mrst_addr", patch_addr_o, 0);
    chk("mrst_x", 32'(patch_x_o), 0);
    chk("mrst_irq", 32'(irq_o), 0);
    rdy_pct = 0; done_q.delete();
    cyc();
    wb_read(BA + 32'h4, rd); chk("mrst_status", rd, 0);
    wb_read(BA + 32'h8, rd); chk("mrst_base", rd, 0);
    wb_read(BA + 32'h0, rd); chk("mrst_ctrl", rd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
